// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic operand path: feeder states,
// lane delay / flush length rules and the lane slicing helper.
package systolic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic int LANE_DELAY(input int i);
      return i + 1;
   endfunction

   function automatic int FLUSH_LEN(input int n);
      return 2 * n - 1;
   endfunction

   // LSB of lane 'lane' in a packed vector of dw-wide lanes
   function automatic int lane_lsb(input int lane, input int dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand beat / control bundle between an upstream source and
// the skew feeder.
interface systolic_skew_feeder_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int KW = 8
);

   logic            start;
   logic [KW-1:0]   k_len;
   logic [N*DW-1:0] a_vec;
   logic [N*DW-1:0] b_vec;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_out;
   logic [N*DW-1:0] b_out;
   logic            acc_clear;
   logic            busy;
   logic            done;

   modport master (
      output start,
      output k_len,
      output a_vec,
      output b_vec,
      output in_valid,
      input  in_ready,
      input  a_out,
      input  b_out,
      input  acc_clear,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  k_len,
      input  a_vec,
      input  b_vec,
      input  in_valid,
      output in_ready,
      output a_out,
      output b_out,
      output acc_clear,
      output busy,
      output done
   );

endinterface

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth free-running shift register; one per skewed lane.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] i_d,
   output logic [DW-1:0] o_q
);

   logic [DW-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder: re-times A/B beats into the diagonal wavefront
// of an NxN systolic array, flushes, then pulses done.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int KW = 8
) (
   input logic clk,
   input logic rst,
   systolic_skew_feeder_if.slave bus
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_STREAM = ST_STREAM;
   localparam logic [1:0] S_FLUSH  = ST_FLUSH;
   localparam logic [1:0] S_DONE   = ST_DONE;

   localparam int FL = FLUSH_LEN(N);
   localparam int FW = $clog2(FL);

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [KW-1:0]   r_k_len;
   logic [KW-1:0]   r_beat_cnt;
   logic [FW-1:0]   r_flush_cnt;
   logic            r_first;

   logic            w_accept;
   logic            w_last_beat;
   logic            w_flush_end;
   logic            w_start_pass;
   logic [N*DW-1:0] w_a_in;
   logic [N*DW-1:0] w_b_in;
   logic [N*DW-1:0] w_a_out;
   logic [N*DW-1:0] w_b_out;

   assign w_accept     = bus.in_valid & (r_state == S_STREAM);
   assign w_last_beat  = w_accept &
                         (r_beat_cnt == r_k_len - KW'(1));
   assign w_flush_end  = (r_flush_cnt == FW'(FL - 1));
   assign w_start_pass = (r_state == S_IDLE) & bus.start &
                         (bus.k_len != '0);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start)
               w_state_nxt = (bus.k_len == '0) ? S_DONE : S_STREAM;
         end
         S_STREAM: begin
            if (w_last_beat) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_flush_end) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k_len     <= '0;
         r_beat_cnt  <= '0;
         r_flush_cnt <= '0;
         r_first     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_first <= w_start_pass;
         if (w_start_pass) begin
            r_k_len    <= bus.k_len;
            r_beat_cnt <= '0;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
         end
         if (r_state == S_FLUSH)
            r_flush_cnt <= r_flush_cnt + FW'(1);
         else
            r_flush_cnt <= '0;
      end
   end

   // Non-accept cycles push a uniform zero bubble into every lane
   assign w_a_in = w_accept ? bus.a_vec : '0;
   assign w_b_in = w_accept ? bus.b_vec : '0;

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(
         .DEPTH (LANE_DELAY(i)),
         .DW    (DW)
      ) u_a_dly (
         .clk (clk),
         .rst (rst),
         .i_d (w_a_in[lane_lsb(i, DW) +: DW]),
         .o_q (w_a_out[lane_lsb(i, DW) +: DW])
      );
      skew_delay_line #(
         .DEPTH (LANE_DELAY(i)),
         .DW    (DW)
      ) u_b_dly (
         .clk (clk),
         .rst (rst),
         .i_d (w_b_in[lane_lsb(i, DW) +: DW]),
         .o_q (w_b_out[lane_lsb(i, DW) +: DW])
      );
   end

   assign bus.a_out     = w_a_out;
   assign bus.b_out     = w_b_out;
   assign bus.in_ready  = (r_state == S_STREAM);
   assign bus.acc_clear = r_first;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: N=2 vector tables plus an N=4
// scoreboarded pass driving a behavioural 4x4 PE array.
module tb_systolic_skew_feeder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_skew_feeder_if #(.N(2), .DW(8), .KW(8)) bus2 ();
   systolic_skew_feeder_if #(.N(4), .DW(8), .KW(8)) bus4 ();

   systolic_skew_feeder #(.N(2), .DW(8), .KW(8)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   systolic_skew_feeder #(.N(4), .DW(8), .KW(8)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   typedef struct {
      logic        start;
      logic [7:0]  k;
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        rdy;
      logic        clr;
      logic        bsy;
      logic        dn;
   } vec_t;

   typedef struct {
      int         cyc;
      bit         is_b;
      int         lane;
      logic [7:0] val;
   } sb_t;

   int n_cmp = 0;
   int n_err = 0;

   vec_t t_basic[$];
   vec_t t_bubble[$];
   vec_t t_zero[$];
   sb_t  sbq[$];

   function automatic vec_t row(
      logic s, logic [7:0] k, logic v,
      logic [15:0] a, logic [15:0] b,
      logic [15:0] ea, logic [15:0] eb,
      logic rdy, logic clr, logic bsy, logic dn);
      vec_t r;
      r.start = s; r.k = k; r.v = v; r.a = a; r.b = b;
      r.ea = ea; r.eb = eb;
      r.rdy = rdy; r.clr = clr; r.bsy = bsy; r.dn = dn;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [35:0] out2();
      return {bus2.a_out, bus2.b_out, bus2.in_ready,
              bus2.acc_clear, bus2.busy, bus2.done};
   endfunction

   task automatic idle2();
      bus2.start = 1'b0; bus2.k_len = '0; bus2.in_valid = 1'b0;
      bus2.a_vec = '0;   bus2.b_vec = '0;
   endtask

   task automatic idle4();
      bus4.start = 1'b0; bus4.k_len = '0; bus4.in_valid = 1'b0;
      bus4.a_vec = '0;   bus4.b_vec = '0;
   endtask

   task automatic run_table(input vec_t t[$], input bit noise,
                            input string nm);
      for (int r = 0; r < t.size(); r++) begin
         @(negedge clk);
         bus2.start    = t[r].start;
         bus2.k_len    = t[r].k;
         bus2.in_valid = t[r].v;
         bus2.a_vec    = t[r].a;
         bus2.b_vec    = t[r].b;
         if (noise && !t[r].rdy && t[r].bsy && !t[r].dn) begin
            bus2.start    = 1'b1;
            bus2.k_len    = 8'd3;
            bus2.in_valid = 1'b1;
            bus2.a_vec    = 16'($urandom);
            bus2.b_vec    = 16'($urandom);
         end
         #1;
         chk($sformatf("%s_row%0d", nm, r), 64'(out2()),
             64'({t[r].ea, t[r].eb, t[r].rdy, t[r].clr,
                  t[r].bsy, t[r].dn}));
      end
      idle2();
   endtask

   task automatic reset_mid_pass();
      bit bad;
      @(negedge clk); bus2.start = 1'b1; bus2.k_len = 8'd2;
      @(negedge clk); bus2.start = 1'b0;
      bus2.in_valid = 1'b1; bus2.a_vec = 16'h0103; bus2.b_vec = 16'h0502;
      @(negedge clk);
      bus2.a_vec = 16'h0402; bus2.b_vec = 16'h0104;
      @(negedge clk);
      idle2();
      #1;
      chk("rstmid_pre_flush", 64'(out2()), 64'({16'h0102, 16'h0504,
          1'b0, 1'b0, 1'b1, 1'b0}));
      rst = 1'b1;
      #1;
      chk("rstmid_outputs_zero", 64'(out2()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (bus2.done || bus2.busy) bad = 1'b1;
      end
      chk("rstmid_no_done", 64'(bad), 64'd0);
   endtask

   task automatic e2e();
      logic [7:0] A [4][5];
      logic [7:0] B [5][4];
      logic [7:0] acc [4][4];
      logic [7:0] ra [4][4];
      logic [7:0] rb [4][4];
      logic [7:0] ca [4][4];
      logic [7:0] cb [4][4];
      logic [7:0] refv;
      logic [31:0] ea, eb;
      int beat, last_acc, cyc;
      bit got_done;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 5; k++) begin
            A[i][k] = 8'($urandom);
            B[k][i] = 8'($urandom);
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc[i][j] = '0; ra[i][j] = '0; rb[i][j] = '0;
         end
      beat = 0; last_acc = 0; cyc = 0; got_done = 1'b0;
      sbq.delete();
      for (int c = 0; c < 200 && !got_done; c++) begin
         @(negedge clk);
         cyc++;
         #1;
         ea = '0; eb = '0;
         for (int q = sbq.size() - 1; q >= 0; q--) begin
            if (sbq[q].cyc == cyc) begin
               if (sbq[q].is_b) eb[sbq[q].lane*8 +: 8] = sbq[q].val;
               else             ea[sbq[q].lane*8 +: 8] = sbq[q].val;
               sbq.delete(q);
            end
         end
         chk($sformatf("e2e_lanes_c%0d", cyc),
             {bus4.a_out, bus4.b_out}, {ea, eb});
         if (bus4.done) begin
            got_done = 1'b1;
            chk("e2e_done_time", 64'(cyc), 64'(last_acc + 8));
            chk("e2e_sb_empty", 64'(sbq.size()), 64'd0);
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++) begin
                  refv = '0;
                  for (int k = 0; k < 5; k++)
                     refv = refv + 8'(A[i][k] * B[k][j]);
                  chk($sformatf("e2e_pe_%0d_%0d", i, j),
                      64'(acc[i][j]), 64'(refv));
               end
         end else begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++) begin
                  ca[i][j] = (j == 0) ? bus4.a_out[i*8 +: 8] : ra[i][j-1];
                  cb[i][j] = (i == 0) ? bus4.b_out[j*8 +: 8] : rb[i-1][j];
               end
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++) begin
                  if (bus4.acc_clear) acc[i][j] = '0;
                  else acc[i][j] = acc[i][j] + 8'(ca[i][j] * cb[i][j]);
                  ra[i][j] = ca[i][j];
                  rb[i][j] = cb[i][j];
               end
            bus4.start = (cyc == 1);
            bus4.k_len = 8'd5;
            bus4.a_vec = 32'($urandom);
            bus4.b_vec = 32'($urandom);
            if (bus4.in_ready) begin
               bus4.in_valid = 1'b0;
               if (beat < 5 && $urandom_range(0, 2) != 0) begin
                  bus4.in_valid = 1'b1;
                  for (int i = 0; i < 4; i++) begin
                     bus4.a_vec[i*8 +: 8] = A[i][beat];
                     bus4.b_vec[i*8 +: 8] = B[beat][i];
                     sbq.push_back('{cyc + 1 + i, 1'b0, i, A[i][beat]});
                     sbq.push_back('{cyc + 1 + i, 1'b1, i, B[beat][i]});
                  end
                  beat++;
                  last_acc = cyc;
               end
            end else begin
               bus4.in_valid = 1'($urandom_range(0, 1));
            end
         end
      end
      if (!got_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL e2e_timeout: got no done expected done");
      end
      idle4();
   endtask

   initial begin
      t_basic.push_back(row(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      t_basic.push_back(row(0, 0, 1, 16'h0103, 16'h0502, 0, 0,
                            1, 1, 1, 0));
      t_basic.push_back(row(0, 0, 1, 16'h0402, 16'h0104,
                            16'h0003, 16'h0002, 1, 0, 1, 0));
      t_basic.push_back(row(0, 0, 0, 0, 0, 16'h0102, 16'h0504,
                            0, 0, 1, 0));
      t_basic.push_back(row(0, 0, 0, 0, 0, 16'h0400, 16'h0100,
                            0, 0, 1, 0));
      t_basic.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      t_basic.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      t_basic.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      t_bubble.push_back(row(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      t_bubble.push_back(row(0, 0, 1, 16'h0103, 16'h0502, 0, 0,
                             1, 1, 1, 0));
      t_bubble.push_back(row(0, 0, 0, 16'hEEEE, 16'hDDDD,
                             16'h0003, 16'h0002, 1, 0, 1, 0));
      t_bubble.push_back(row(0, 0, 1, 16'h0402, 16'h0104,
                             16'h0100, 16'h0500, 1, 0, 1, 0));
      t_bubble.push_back(row(0, 0, 0, 0, 0, 16'h0002, 16'h0004,
                             0, 0, 1, 0));
      t_bubble.push_back(row(0, 0, 0, 0, 0, 16'h0400, 16'h0100,
                             0, 0, 1, 0));
      t_bubble.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      t_bubble.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      t_bubble.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      t_zero.push_back(row(1, 0, 1, 16'h1111, 16'h2222, 0, 0,
                           0, 0, 0, 0));
      t_zero.push_back(row(0, 0, 1, 16'h3333, 16'h4444, 0, 0,
                           0, 0, 1, 1));
      t_zero.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      t_zero.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      t_zero.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      rst = 1'b1;
      idle2();
      idle4();
      @(negedge clk);
      @(negedge clk);
      chk("reset_n2", 64'(out2()), 64'd0);
      chk("reset_n4", {bus4.a_out, bus4.b_out},  64'd0);
      chk("reset_n4_ctl", 64'({bus4.in_ready, bus4.acc_clear,
          bus4.busy, bus4.done}), 64'd0);
      rst = 1'b0;

      run_table(t_basic,  1'b0, "basic");
      run_table(t_basic,  1'b1, "ignored");
      run_table(t_bubble, 1'b0, "bubble");
      run_table(t_zero,   1'b0, "zero_len");
      reset_mid_pass();
      run_table(t_basic,  1'b0, "after_rst");
      e2e();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream operand feeder for the N×N systolic array of `pe_module` tiles. It accepts one K-step beat of operands per cycle: a column slice of A (N lanes) and a row slice of B (N lanes). It re-times them into the diagonal wavefront the array requires, so lane i is delayed i cycles relative to lane 0. A-lanes drive `in1` of the left-edge PEs and B-lanes drive `in2` of the top-edge PEs. After the last beat it flushes zeros until the far-corner PE holds its final result, then pulses `done`.

## Interface
- `N`, 4, array dimension (lanes per operand); legal 2..16
- `DW`, 8, operand width per lane
- `KW`, 8, width of the K-length field
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a K-pass; sampled only in IDLE
- `k_len`  in  KW  beats in the pass; latched on `start`
- `a_vec`  in  N*DW  A beat; lane i = bits [i*DW +: DW], for array row i
- `b_vec`  in  N*DW  B beat; lane j = bits [j*DW +: DW], for array column j
- `in_valid`  in  1  beat present on `a_vec`/`b_vec`
- `in_ready`  out  1  feeder accepts a beat this cycle
- `a_out`  out  N*DW  skewed A lanes, to `in1` of PE(i,0)
- `b_out`  out  N*DW  skewed B lanes, to `in2` of PE(0,j)
- `acc_clear`  out  1  one-cycle pulse that clears array accumulators
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse; array results are final

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- **IDLE:**
  - `start` with `k_len` ≠ 0 → STREAM; latch `k_len`; beat counter cleared.
  - `start` with `k_len` = 0 → DONE directly; no `acc_clear`, no data.
- **STREAM:**
  - `in_ready` = 1.
  - A beat is accepted when `in_valid & in_ready`; the counter increments on each acceptance.
  - On acceptance of beat `k_len` → FLUSH.
- **FLUSH:**
  - `in_ready` = 0.
  - A counter runs 2N-1 cycles, then the block enters DONE.
- **DONE:** one cycle; `done` = 1; → IDLE.
- **`acc_clear`:** high in the first STREAM cycle only.
- **`busy`:** high in STREAM, FLUSH and DONE.
- **Skew:**
  - Each A lane and B lane i is a delay line of depth i+1; all lines shift every cycle, never stall.
  - An accepted beat enters all lines. A cycle with no acceptance inserts 0 on every lane.
  - Zero bubbles are uniform across lanes, so they preserve diagonal alignment and add 0 to every dot product.
- `start` while not in IDLE is ignored. `in_valid` outside STREAM is ignored.
- Data is passed unmodified; no arithmetic and no width change.

## Timing
- Beat accepted in cycle T appears on A/B lane i in cycle T+1+i.
- Last accept at cycle T:
  - FLUSH covers T+1 … T+2N-1.
  - `done` is asserted in cycle T+2N.
  - IDLE is re-entered at T+2N+1.
- `start` in cycle S → STREAM (with `acc_clear`) in S+1; earliest accept in S+1.
- **Reset (any time, including mid-pass):**
  - State → IDLE.
  - All delay registers and counters cleared.
  - Outputs: `a_out`=0, `b_out`=0, `in_ready`=0, `acc_clear`=0, `busy`=0, `done`=0.
  - A pass interrupted by reset produces no `done`.
- Back-to-back passes: `start` in the cycle after `done` is accepted.

## Structure
- **Shared package (`systolic_pkg`):**
  - State enum.
  - `LANE_DELAY(i) = i+1`.
  - `FLUSH_LEN(N) = 2*N-1`.
  - Lane slicing helper, shared with `pe_module` array wrappers.
- **Sub-module `skew_delay_line`:**
  - Parameters `DEPTH` and `DW`; async-reset shift register.
  - Instanced 2N times by generate: one per A lane, one per B lane.
- **Top level:** FSM, beat counter, flush counter, lane muxing of 0 vs. beat.

## Test plan
- **Basic pass** (N=2; `start`, `k_len`=2 at cycle 0; beats at cycles 1,2: `a_vec` lanes (3,1) then (2,4); `b_vec` lanes (2,5) then (4,1)):
  - A lane0 = 3 @2, 2 @3; A lane1 = 1 @3, 4 @4.
  - B lane0 = 2 @2, 4 @3; B lane1 = 5 @3, 1 @4.
  - Zeros elsewhere; `acc_clear` @1; `done` @6.
- **Bubble** (same beats, `in_valid` low at cycle 2, second beat accepted at 3):
  - A lane0 = 3 @2, 0 @3, 2 @4.
  - `done` @7.
- **Zero length** (`k_len`=0):
  - `done` in the next cycle; no `acc_clear`; `in_ready` never high.
- **Reset mid-pass** (assert `rst` during FLUSH):
  - All outputs 0 immediately; no `done`.
  - A new `start` afterwards runs a normal pass.
- **Ignored inputs** (`start` and `in_valid` during FLUSH):
  - No effect; timing identical to the basic pass.
- **End-to-end** (N=4 with 4×4 `pe_module` array, random 8-bit A (4×K) and B (K×4), K=5, random `in_valid` gaps):
  - At `done`, every PE result equals the reference product mod 2^8.
